// File: rtl/output_mem_ctrl_if.sv
// Bundles the pixel, buffer-address, write-master and frame-control signals
// of output_mem_ctrl. The controller connects through the slave modport.
interface output_mem_ctrl_if;
  logic        I_OCTL_START;
  logic [31:0] I_OCTL_BASE_ADDR;
  logic        I_OCTL_PIX_VALID;
  logic        I_OCTL_PIX_LAST;
  logic        O_OCTL_PIX_READY;
  logic [7:0]  O_OCTL_IN_ADDRB;
  logic [7:0]  O_OCTL_IN_ADDRG;
  logic [7:0]  O_OCTL_IN_ADDRR;
  logic [7:0]  O_OCTL_OUT_ADDR0;
  logic [7:0]  O_OCTL_OUT_ADDR1;
  logic [7:0]  O_OCTL_OUT_ADDR2;
  logic [7:0]  O_OCTL_OUT_ADDR3;
  logic        O_OCTL_WVALID;
  logic        I_OCTL_WREADY;
  logic [31:0] O_OCTL_WADDR;
  logic        O_OCTL_BUSY;
  logic        O_OCTL_DONE;
  logic [15:0] O_OCTL_STALL_CNT;

  modport slave (
    input  I_OCTL_START, I_OCTL_BASE_ADDR, I_OCTL_PIX_VALID, I_OCTL_PIX_LAST,
           I_OCTL_WREADY,
    output O_OCTL_PIX_READY, O_OCTL_IN_ADDRB, O_OCTL_IN_ADDRG, O_OCTL_IN_ADDRR,
           O_OCTL_OUT_ADDR0, O_OCTL_OUT_ADDR1, O_OCTL_OUT_ADDR2, O_OCTL_OUT_ADDR3,
           O_OCTL_WVALID, O_OCTL_WADDR, O_OCTL_BUSY, O_OCTL_DONE, O_OCTL_STALL_CNT
  );

  modport master (
    output I_OCTL_START, I_OCTL_BASE_ADDR, I_OCTL_PIX_VALID, I_OCTL_PIX_LAST,
           I_OCTL_WREADY,
    input  O_OCTL_PIX_READY, O_OCTL_IN_ADDRB, O_OCTL_IN_ADDRG, O_OCTL_IN_ADDRR,
           O_OCTL_OUT_ADDR0, O_OCTL_OUT_ADDR1, O_OCTL_OUT_ADDR2, O_OCTL_OUT_ADDR3,
           O_OCTL_WVALID, O_OCTL_WADDR, O_OCTL_BUSY, O_OCTL_DONE, O_OCTL_STALL_CNT
  );
endinterface

// File: rtl/output_mem_ctrl.sv
// Ping-pong sequencer for the 64-byte output pixel buffer: fills one bank with
// B/G/R pixels while draining the other as 32-bit words to the AHB write master.
// Define OCTL_STALL_CNT_EN to build the write-stall cycle counter.
module output_mem_ctrl #(
  parameter int unsigned PIX_PER_BANK = 8,
  parameter int unsigned BANK1_BASE   = 32,
  parameter int unsigned IDLE_ADDR    = 61
) (
  input  logic              I_OCTL_HCLK,
  input  logic              I_OCTL_HRESET,
  output_mem_ctrl_if.slave  octl
);

  localparam logic [7:0] BANK1 = 8'(BANK1_BASE);
  localparam logic [7:0] PARK  = 8'(IDLE_ADDR);
  localparam logic [2:0] K_MAX = 3'(PIX_PER_BANK - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_DATA} drain_state_e;

  drain_state_e state_q, state_d;

  logic        busy_q;
  logic        done_q;
  logic        last_seen_q;
  logic        wb_q;
  logic        rb_q;
  logic [1:0]  full_q, full_d;
  logic [2:0]  cnt_q;
  logic [2:0]  nwords_q [2];
  logic [2:0]  w_q;
  logic [31:0] ptr_q;

  logic        start_acc;
  logic        pix_ready;
  logic        pix_xfer;
  logic        bank_close;
  logic [4:0]  fill_bytes;
  logic [2:0]  close_words;
  logic [7:0]  wr_base;
  logic [7:0]  wr_off;
  logic [7:0]  rd_word;
  logic        wvalid;
  logic        word_release;
  logic        last_word;
  logic        bank_release;
  logic        done_cond;

  assign start_acc  = octl.I_OCTL_START & ~busy_q;
  assign pix_ready  = busy_q & ~full_q[wb_q] & ~last_seen_q;
  assign pix_xfer   = octl.I_OCTL_PIX_VALID & pix_ready;
  assign bank_close = pix_xfer & ((cnt_q == K_MAX) | octl.I_OCTL_PIX_LAST);

  // Words in a closing bank: ceil(3*(k+1)/4); a partial tail word is still sent whole.
  assign fill_bytes  = 5'd3 * ({2'b00, cnt_q} + 5'd1);
  assign close_words = 3'((fill_bytes + 5'd3) >> 2);

  assign wr_base = wb_q ? BANK1 : '0;
  assign wr_off  = 8'(cnt_q) * 8'd3;
  assign rd_word = (rb_q ? BANK1 : 8'd0) + {3'b000, w_q, 2'b00};

  assign word_release = wvalid & octl.I_OCTL_WREADY;
  assign last_word    = (w_q == nwords_q[rb_q] - 3'd1);
  assign bank_release = word_release & last_word;
  assign done_cond    = busy_q & last_seen_q & ~|full_q & (state_q == S_IDLE);

  // Close and release never hit the same bank, so both edits can apply together.
  always_comb begin
    full_d = full_q;
    if (bank_close)   full_d[wb_q] = 1'b1;
    if (bank_release) full_d[rb_q] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    wvalid  = 1'b0;
    unique case (state_q)
      S_IDLE: if (full_q[rb_q]) state_d = S_ADDR;
      S_ADDR: state_d = S_WAIT;
      S_WAIT: state_d = S_DATA;
      S_DATA: begin
        wvalid = 1'b1;
        if (octl.I_OCTL_WREADY) state_d = last_word ? S_IDLE : S_ADDR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_OCTL_HCLK) begin
    if (I_OCTL_HRESET) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      last_seen_q <= 1'b0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      full_q      <= '0;
      cnt_q       <= '0;
      nwords_q[0] <= '0;
      nwords_q[1] <= '0;
      w_q         <= '0;
      ptr_q       <= '0;
    end else if (start_acc) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      last_seen_q <= 1'b0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      full_q      <= '0;
      cnt_q       <= '0;
      w_q         <= '0;
      ptr_q       <= octl.I_OCTL_BASE_ADDR;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      done_q  <= done_cond;
      if (done_cond) begin
        busy_q      <= 1'b0;
        last_seen_q <= 1'b0;
      end
      if (pix_xfer) begin
        if (bank_close) begin
          nwords_q[wb_q] <= close_words;
          wb_q           <= ~wb_q;
          cnt_q          <= '0;
          if (octl.I_OCTL_PIX_LAST) last_seen_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 3'd1;
        end
      end
      if (word_release) begin
        ptr_q <= ptr_q + 32'd4;
        if (last_word) begin
          w_q  <= '0;
          rb_q <= ~rb_q;
        end else begin
          w_q <= w_q + 3'd1;
        end
      end
    end
  end

`ifdef OCTL_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge I_OCTL_HCLK) begin
    if (I_OCTL_HRESET)
      stall_q <= '0;
    else if (start_acc)
      stall_q <= '0;
    else if (wvalid && !octl.I_OCTL_WREADY && stall_q != '1)
      stall_q <= stall_q + 16'd1;
  end

  assign octl.O_OCTL_STALL_CNT = stall_q;
`else
  assign octl.O_OCTL_STALL_CNT = '0;
`endif

  // The buffer writes every cycle, so idle cycles park on addresses outside both banks.
  assign octl.O_OCTL_PIX_READY = pix_ready;
  assign octl.O_OCTL_IN_ADDRB  = pix_xfer ? wr_base + wr_off          : PARK;
  assign octl.O_OCTL_IN_ADDRG  = pix_xfer ? wr_base + wr_off + 8'd1   : PARK + 8'd1;
  assign octl.O_OCTL_IN_ADDRR  = pix_xfer ? wr_base + wr_off + 8'd2   : PARK + 8'd2;
  assign octl.O_OCTL_OUT_ADDR0 = rd_word;
  assign octl.O_OCTL_OUT_ADDR1 = rd_word + 8'd1;
  assign octl.O_OCTL_OUT_ADDR2 = rd_word + 8'd2;
  assign octl.O_OCTL_OUT_ADDR3 = rd_word + 8'd3;
  assign octl.O_OCTL_WVALID    = wvalid;
  assign octl.O_OCTL_WADDR     = ptr_q;
  assign octl.O_OCTL_BUSY      = busy_q;
  assign octl.O_OCTL_DONE      = done_q;

  a_wvalid_hold: assert property (@(posedge I_OCTL_HCLK) disable iff (I_OCTL_HRESET)
    (wvalid && !octl.I_OCTL_WREADY) |=> wvalid);

  a_banks_apart: assert property (@(posedge I_OCTL_HCLK) disable iff (I_OCTL_HRESET)
    !(pix_xfer && state_q != S_IDLE && wb_q == rb_q));

endmodule

// File: tb/tb_output_mem_ctrl.sv
// Scoreboard bench for output_mem_ctrl: stimulus queues expected write/read
// addresses, a negedge monitor pops and compares on every handshake.
module tb_output_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  output_mem_ctrl_if octl ();

  output_mem_ctrl #(
    .PIX_PER_BANK (8),
    .BANK1_BASE   (32),
    .IDLE_ADDR    (61)
  ) dut (
    .I_OCTL_HCLK   (clk),
    .I_OCTL_HRESET (rst),
    .octl          (octl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] waddr;
    logic [7:0]  raddr;
  } word_t;

  logic [7:0]  pix_q [$];
  word_t       word_q [$];
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          words_seen = 0;
  logic [31:0] last_waddr = '0;
  logic [7:0]  mon_b;
  word_t       mon_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (octl.O_OCTL_DONE) begin
      done_cnt++;
      chk("busy_clear_at_done", 32'(octl.O_OCTL_BUSY), 32'd0);
    end
    if (octl.I_OCTL_PIX_VALID && octl.O_OCTL_PIX_READY) begin
      if (pix_q.size() == 0) chk("pix_unexpected", 32'(pix_q.size()), 32'd1);
      else begin
        mon_b = pix_q.pop_front();
        chk("in_addrb", 32'(octl.O_OCTL_IN_ADDRB), 32'(mon_b));
        chk("in_addrg", 32'(octl.O_OCTL_IN_ADDRG), 32'(mon_b + 8'd1));
        chk("in_addrr", 32'(octl.O_OCTL_IN_ADDRR), 32'(mon_b + 8'd2));
      end
    end
    if (octl.O_OCTL_WVALID && octl.I_OCTL_WREADY) begin
      words_seen++;
      last_waddr = octl.O_OCTL_WADDR;
      if (word_q.size() == 0) chk("word_unexpected", 32'(word_q.size()), 32'd1);
      else begin
        mon_w = word_q.pop_front();
        chk("waddr", octl.O_OCTL_WADDR, mon_w.waddr);
        chk("out_addr0", 32'(octl.O_OCTL_OUT_ADDR0), 32'(mon_w.raddr));
        chk("out_addr1", 32'(octl.O_OCTL_OUT_ADDR1), 32'(mon_w.raddr + 8'd1));
        chk("out_addr2", 32'(octl.O_OCTL_OUT_ADDR2), 32'(mon_w.raddr + 8'd2));
        chk("out_addr3", 32'(octl.O_OCTL_OUT_ADDR3), 32'(mon_w.raddr + 8'd3));
      end
    end
  end

  // Pixel i lands in bank (i/8)%2 at byte 3*(i%8); each bank chunk of n pixels drains ceil(3n/4) words.
  task automatic expect_frame(input logic [31:0] base, input int npix);
    int rem = npix;
    int gw = 0;
    int bank = 0;
    for (int i = 0; i < npix; i++)
      pix_q.push_back(8'(((i / 8) % 2) * 32 + 3 * (i % 8)));
    while (rem > 0) begin
      int n = (rem > 8) ? 8 : rem;
      int nw = (3 * n + 3) / 4;
      for (int w = 0; w < nw; w++) begin
        word_q.push_back('{waddr: base + 32'(4 * gw), raddr: 8'(bank * 32 + 4 * w)});
        gw++;
      end
      rem -= n;
      bank = 1 - bank;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"},   32'(octl.O_OCTL_BUSY), 32'd0);
    chk({tag, "_done"},   32'(octl.O_OCTL_DONE), 32'd0);
    chk({tag, "_wvalid"}, 32'(octl.O_OCTL_WVALID), 32'd0);
    chk({tag, "_ready"},  32'(octl.O_OCTL_PIX_READY), 32'd0);
    chk({tag, "_inb"},    32'(octl.O_OCTL_IN_ADDRB), 32'd61);
    chk({tag, "_ing"},    32'(octl.O_OCTL_IN_ADDRG), 32'd62);
    chk({tag, "_inr"},    32'(octl.O_OCTL_IN_ADDRR), 32'd63);
    chk({tag, "_out0"},   32'(octl.O_OCTL_OUT_ADDR0), 32'd0);
    chk({tag, "_out1"},   32'(octl.O_OCTL_OUT_ADDR1), 32'd1);
    chk({tag, "_out2"},   32'(octl.O_OCTL_OUT_ADDR2), 32'd2);
    chk({tag, "_out3"},   32'(octl.O_OCTL_OUT_ADDR3), 32'd3);
    chk({tag, "_waddr"},  octl.O_OCTL_WADDR, 32'd0);
  endtask

  task automatic start_frame(input logic [31:0] base);
    words_seen = 0;
    octl.I_OCTL_START = 1'b1;
    octl.I_OCTL_BASE_ADDR = base;
    @(posedge clk); #1;
    octl.I_OCTL_START = 1'b0;
  endtask

  task automatic send(input int n, input bit with_last, output int drops);
    drops = 0;
    for (int i = 0; i < n; i++) begin
      int cyc = 0;
      octl.I_OCTL_PIX_VALID = 1'b1;
      octl.I_OCTL_PIX_LAST  = with_last && (i == n - 1);
      @(negedge clk);
      while (!octl.O_OCTL_PIX_READY && cyc < 300) begin
        @(negedge clk);
        cyc++;
      end
      if (cyc >= 300) begin
        chk("pix_ready_timeout", 32'(cyc), 32'd0);
        break;
      end
      drops += cyc;
      @(posedge clk); #1;
    end
    octl.I_OCTL_PIX_VALID = 1'b0;
    octl.I_OCTL_PIX_LAST  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    int cyc = 0;
    while (done_cnt == d0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
    repeat (5) @(negedge clk);
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_busy_off"},  32'(octl.O_OCTL_BUSY), 32'd0);
    chk({tag, "_words_left"}, 32'(word_q.size()), 32'd0);
    chk({tag, "_pix_left"},   32'(pix_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_wvalid(input string tag);
    int cyc = 0;
    @(negedge clk);
    while (!octl.O_OCTL_WVALID && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_wvalid_rise"}, 32'(octl.O_OCTL_WVALID), 32'd1);
  endtask

  initial begin
    int drops;
    octl.I_OCTL_START     = 1'b0;
    octl.I_OCTL_BASE_ADDR = '0;
    octl.I_OCTL_PIX_VALID = 1'b0;
    octl.I_OCTL_PIX_LAST  = 1'b0;
    octl.I_OCTL_WREADY    = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("rst");
    chk("rst_stall", 32'(octl.O_OCTL_STALL_CNT), 32'd0);
    @(posedge clk); #1;

    // One full bank, LAST on pixel 8.
    expect_frame(32'h1000, 8);
    start_frame(32'h1000);
    send(8, 1'b1, drops);
    wait_done("t1", 200);
    chk("t1_words", 32'(words_seen), 32'd6);
    chk("t1_last_waddr", last_waddr, 32'h1014);

    // Two banks back to back: bank 1 fills while bank 0 drains.
    expect_frame(32'h2000, 16);
    start_frame(32'h2000);
    send(16, 1'b1, drops);
    chk("t2_ready_drops", 32'(drops), 32'd0);
    wait_done("t2", 300);
    chk("t2_words", 32'(words_seen), 32'd12);
    chk("t2_last_waddr", last_waddr, 32'h202C);

    // Short frame: 5 pixels -> 15 bytes -> 4 words.
    expect_frame(32'h3000, 5);
    start_frame(32'h3000);
    send(5, 1'b1, drops);
    wait_done("t3", 200);
    chk("t3_words", 32'(words_seen), 32'd4);
    chk("t3_last_waddr", last_waddr, 32'h300C);

    // Ten stalled cycles on word 0.
    octl.I_OCTL_WREADY = 1'b0;
    expect_frame(32'h4000, 8);
    start_frame(32'h4000);
    send(8, 1'b1, drops);
    wait_wvalid("t4");
    for (int i = 0; i < 10; i++) begin
      chk("t4_wvalid_hold", 32'(octl.O_OCTL_WVALID), 32'd1);
      chk("t4_waddr_hold",  octl.O_OCTL_WADDR, 32'h4000);
      chk("t4_out0_hold",   32'(octl.O_OCTL_OUT_ADDR0), 32'd0);
      if (i < 9) @(negedge clk);
    end
    @(posedge clk); #1;
    octl.I_OCTL_WREADY = 1'b1;
    wait_done("t4", 200);
`ifdef OCTL_STALL_CNT_EN
    chk("t4_stall_cnt", 32'(octl.O_OCTL_STALL_CNT), 32'd10);
`else
    chk("t4_stall_cnt", 32'(octl.O_OCTL_STALL_CNT), 32'd0);
`endif

    // Both banks full with the master blocked: pixel input must stall and park.
    octl.I_OCTL_WREADY = 1'b0;
    expect_frame(32'h5000, 20);
    start_frame(32'h5000);
    send(16, 1'b0, drops);
    octl.I_OCTL_PIX_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_ready_low", 32'(octl.O_OCTL_PIX_READY), 32'd0);
      chk("t5_inb_park",  32'(octl.O_OCTL_IN_ADDRB), 32'd61);
      chk("t5_ing_park",  32'(octl.O_OCTL_IN_ADDRG), 32'd62);
      chk("t5_inr_park",  32'(octl.O_OCTL_IN_ADDRR), 32'd63);
    end
    @(posedge clk); #1;
    octl.I_OCTL_WREADY = 1'b1;
    send(4, 1'b1, drops);
    wait_done("t5", 400);
    chk("t5_words", 32'(words_seen), 32'd15);
    chk("t5_last_waddr", last_waddr, 32'h5038);

    // Reset in the middle of the drain, then a clean frame.
    expect_frame(32'h6000, 8);
    start_frame(32'h6000);
    send(8, 1'b1, drops);
    begin
      int cyc = 0;
      while (words_seen < 1 && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      chk("t6_first_word", 32'(words_seen), 32'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("t6_rst");
    pix_q.delete();
    word_q.delete();
    @(posedge clk); #1;
    expect_frame(32'h7000, 8);
    start_frame(32'h7000);
    send(8, 1'b1, drops);
    wait_done("t6", 200);
    chk("t6_words", 32'(words_seen), 32'd6);
    chk("t6_last_waddr", last_waddr, 32'h7014);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/output_mem_ctrl.md
Name: output_mem_ctrl

Overview:
- Sequencer for the 64-byte output pixel buffer.
- Accepts rotated B/G/R pixels from the rotation engine over a valid/ready handshake and steers them into two ping-pong banks by driving the buffer's three write addresses.
- Drains each full bank as 32-bit words by driving the buffer's four read addresses, then presents the words and bus addresses to the AHB write master with a valid/ready handshake.

Parameters:
- PIX_PER_BANK, 8, pixels per bank; must be 4 or 8. Bank size is 3*PIX_PER_BANK bytes, 3*PIX_PER_BANK/4 words.
- BANK1_BASE, 32, byte offset of bank 1 in the buffer (bank 0 at 0).
- IDLE_ADDR, 61, first of three parking write addresses (61/62/63), outside both banks.

Ports:
- I_OCTL_HCLK  in  1  clock
- I_OCTL_HRESET  in  1  synchronous reset, active-high
- I_OCTL_START  in  1  frame start pulse; ignored while O_OCTL_BUSY
- I_OCTL_BASE_ADDR  in  32  destination byte address, sampled on accepted START
- I_OCTL_PIX_VALID  in  1  pixel valid from rotation engine
- I_OCTL_PIX_LAST  in  1  qualifies the final pixel of the frame
- O_OCTL_PIX_READY  out  1  pixel accept
- O_OCTL_IN_ADDRB / _IN_ADDRG / _IN_ADDRR  out  8 each  buffer write addresses
- O_OCTL_OUT_ADDR0..3  out  8 each  buffer read addresses
- O_OCTL_WVALID  out  1  buffer write data (2-cycle latency) valid to master
- I_OCTL_WREADY  in  1  master accepts word
- O_OCTL_WADDR  out  32  bus byte address of current word
- O_OCTL_BUSY  out  1  frame in progress
- O_OCTL_DONE  out  1  one-cycle pulse, frame fully written
- O_OCTL_STALL_CNT  out  16  see Optional Feature

Behaviour:
- Reset values:
  - BUSY, DONE, WVALID, PIX_READY = 0
  - IN_ADDRB/G/R = 61/62/63
  - OUT_ADDR0..3 = 0/1/2/3
  - WADDR = 0
  - Write bank, drain bank and full[1:0] = 0
  - Pixel count = 0
  - Drain FSM = IDLE
- Reset mid-frame aborts everything. Buffer contents are not cleared.
- Accepted START: BUSY=1; word address ptr = BASE_ADDR; counters cleared.
- PIX_READY = BUSY & !full[wb] & !last_seen.
- Pixel transfer occurs when VALID & READY. On that cycle (combinational), with k = count and base = bank base:
  - IN_ADDRB = base+3k
  - IN_ADDRG = base+3k+1
  - IN_ADDRR = base+3k+2
  - Otherwise the write addresses park at 61/62/63, because the buffer writes every cycle.
- Bank close occurs on a transfer with k = PIX_PER_BANK-1 or with LAST:
  - full[wb] <= 1
  - nwords[wb] <= ceil(3(k+1)/4)
  - wb toggles; count <= 0
  - LAST additionally sets last_seen.
- Drain FSM:
  - IDLE: go to ADDR if full[rb].
  - ADDR (1 cycle): drive OUT_ADDRj = rbase+4w+j for j = 0..3.
  - WAIT (1 cycle).
  - DATA: WVALID=1, WADDR = ptr. Read addresses are held stable for the whole word.
  - On DATA & WREADY: ptr += 4. If w = nwords-1: full[rb] <= 0, rb toggles, w <= 0, go to IDLE. Otherwise w++, go to ADDR.
- Minimum throughput is 3 cycles per word. WVALID, once high, stays high until WREADY.
- Bank fill and drain always target different banks, so the buffer's write-to-read forwarding never triggers on valid data.
- A fill close and a drain release in the same cycle are both honoured.
- DONE pulses the cycle after last_seen & !full[0] & !full[1] & FSM in IDLE. BUSY clears on that same cycle.
- Partial-word tail bytes are stale buffer contents; the master writes the full word.

Optional Feature:
- Macro OCTL_STALL_CNT_EN.
- Defined: O_OCTL_STALL_CNT counts cycles with WVALID & !WREADY. It saturates at 16'hFFFF, clears on accepted START, and holds after DONE.
- Undefined: O_OCTL_STALL_CNT is tied to 0 and no counter logic is built.

Test Plan:
- Reset, START with BASE=0x1000, 8 pixels with LAST on pixel 8, WREADY=1 -> IN_ADDRB steps 0,3,..21. Six words go out at WADDR 0x1000..0x1014 with OUT_ADDR0 = 0,4,..20. DONE pulses once.
- 16 pixels streamed continuously, WREADY=1 -> bank 1 fill (IN_ADDRB = 32..53) overlaps bank 0 drain. 12 words go out, with no READY drop until bank 1 closes while bank 0 is still draining.
- 5 pixels with LAST -> nwords = 4. WADDR ends at BASE+12; DONE follows.
- WREADY held low 10 cycles on word 0 -> WVALID, WADDR and OUT_ADDR stay stable. With the macro defined, STALL_CNT = 10.
- Both banks full with WREADY low -> PIX_READY=0 and IN_ADDR parked at 61/62/63. Releasing WREADY resumes flow.
- HRESET asserted mid-drain -> next cycle all outputs hold their reset values. A new START runs a clean frame.
